// File: rtl/nmcu_conv_scheduler_if.sv
// Lane/engine-facing bundle of nmcu_conv_scheduler: packed per-lane job requests,
// per-lane responses and the shared convolution engine control/config.
interface nmcu_conv_scheduler_if #(
  parameter int N_REQ          = 4,
  parameter int MAX_INPUT_DIM  = 15,
  parameter int MAX_KERNEL_DIM = 7
);
  localparam int IW = $clog2(MAX_INPUT_DIM) + 1;
  localparam int KW = $clog2(MAX_KERNEL_DIM) + 1;
  localparam int SW = ($clog2(N_REQ) < 1) ? 1 : $clog2(N_REQ);

  logic [N_REQ-1:0]    req;
  logic [N_REQ*IW-1:0] req_width;
  logic [N_REQ*IW-1:0] req_height;
  logic [N_REQ*KW-1:0] req_ksize;
  logic [N_REQ-1:0]    resp_valid;
  logic [N_REQ-1:0]    resp_err;
  logic                busy;
  logic                eng_start;
  logic                eng_rst;
  logic                eng_done;
  logic [IW-1:0]       eng_input_width;
  logic [IW-1:0]       eng_input_height;
  logic [KW-1:0]       eng_kernel_size;
  logic [SW-1:0]       eng_sel;

  modport master (
    input  req, req_width, req_height, req_ksize, eng_done,
    output resp_valid, resp_err, busy, eng_start, eng_rst,
           eng_input_width, eng_input_height, eng_kernel_size, eng_sel
  );

  modport slave (
    output req, req_width, req_height, req_ksize, eng_done,
    input  resp_valid, resp_err, busy, eng_start, eng_rst,
           eng_input_width, eng_input_height, eng_kernel_size, eng_sel
  );
endinterface

// File: rtl/nmcu_conv_scheduler.sv
// Round-robin sharing of one convolution engine between N_REQ lanes: validates the
// granted config, launches the engine, watches for done/timeout and resets it between jobs.
module nmcu_conv_scheduler #(
  parameter int N_REQ          = 4,
  parameter int MAX_INPUT_DIM  = 15,
  parameter int MAX_KERNEL_DIM = 7,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic                  clk,
  input  logic                  rst,
  nmcu_conv_scheduler_if.master bus
);
  localparam int IW = $clog2(MAX_INPUT_DIM) + 1;
  localparam int KW = $clog2(MAX_KERNEL_DIM) + 1;
  localparam int SW = ($clog2(N_REQ) < 1) ? 1 : $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int CW = (IW > KW) ? IW : KW;

  localparam logic [CW-1:0] MAX_IN     = CW'(MAX_INPUT_DIM);
  localparam logic [CW-1:0] MAX_K      = CW'(MAX_KERNEL_DIM);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_LAUNCH, S_WAIT, S_RELEASE, S_REJECT, S_ABORT
  } state_t;

  state_t           state;
  logic [SW-1:0]    rr_ptr;
  logic [SW-1:0]    grant;
  logic [SW-1:0]    pick;
  logic             pick_vld;
  int               idx;
  logic [IW-1:0]    cfg_w;
  logic [IW-1:0]    cfg_h;
  logic [KW-1:0]    cfg_k;
  logic [TW-1:0]    timer;
  logic [N_REQ-1:0] resp_valid_q;
  logic [N_REQ-1:0] resp_err_q;
  logic             busy_q;
  logic             eng_start_q;
  logic             eng_rst_q;

  function automatic logic cfg_ok(input logic [IW-1:0] w, input logic [IW-1:0] h,
                                  input logic [KW-1:0] k);
    logic [CW-1:0] we;
    logic [CW-1:0] he;
    logic [CW-1:0] ke;
    we = CW'(w);
    he = CW'(h);
    ke = CW'(k);
    return (ke != '0) && (ke <= MAX_K) && (we != '0) && (he != '0) &&
           (we <= MAX_IN) && (he <= MAX_IN) && (ke <= we) && (ke <= he);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [SW-1:0] sel);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

  function automatic logic [SW-1:0] next_ptr(input logic [SW-1:0] sel);
    return (sel == SW'(N_REQ - 1)) ? '0 : sel + 1'b1;
  endfunction

  // Scan from rr_ptr upward with wrap; iterating farthest-first lets the nearest hit win.
  always_comb begin
    pick     = rr_ptr;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (bus.req[idx[SW-1:0]]) begin
        pick     = idx[SW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      grant        <= '0;
      cfg_w        <= '0;
      cfg_h        <= '0;
      cfg_k        <= '0;
      timer        <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= '0;
      busy_q       <= 1'b0;
      eng_start_q  <= 1'b0;
      eng_rst_q    <= 1'b0;
    end else begin
      resp_valid_q <= '0;
      resp_err_q   <= '0;
      eng_start_q  <= 1'b0;
      eng_rst_q    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            grant  <= pick;
            cfg_w  <= bus.req_width[pick*IW +: IW];
            cfg_h  <= bus.req_height[pick*IW +: IW];
            cfg_k  <= bus.req_ksize[pick*KW +: KW];
            busy_q <= 1'b1;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          timer <= '0;
          if (cfg_ok(cfg_w, cfg_h, cfg_k)) begin
            eng_start_q <= 1'b1;
            state       <= S_LAUNCH;
          end else begin
            resp_valid_q <= onehot(grant);
            resp_err_q   <= onehot(grant);
            state        <= S_REJECT;
          end
        end
        S_LAUNCH: begin
          timer <= '0;
          state <= S_WAIT;
        end
        // done wins over the watchdog when both land on the last cycle
        S_WAIT: begin
          if (bus.eng_done) begin
            resp_valid_q <= onehot(grant);
            eng_rst_q    <= 1'b1;
            state        <= S_RELEASE;
          end else if (timer == TIMER_LAST) begin
            resp_valid_q <= onehot(grant);
            resp_err_q   <= onehot(grant);
            eng_rst_q    <= 1'b1;
            state        <= S_ABORT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RELEASE, S_REJECT, S_ABORT: begin
          rr_ptr <= next_ptr(grant);
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.resp_valid       = resp_valid_q;
  assign bus.resp_err         = resp_err_q;
  assign bus.busy             = busy_q;
  assign bus.eng_start        = eng_start_q;
  assign bus.eng_rst          = rst | eng_rst_q;
  assign bus.eng_input_width  = cfg_w;
  assign bus.eng_input_height = cfg_h;
  assign bus.eng_kernel_size  = cfg_k;
  assign bus.eng_sel          = grant;

endmodule

// File: doc/nmcu_conv_scheduler.md
Name: nmcu_conv_scheduler

Overview:
- Shares one conv_for_nmcu-style convolution engine between N_REQ requesters (NMCU lanes).
- Round-robin arbitration, config validation and launch of the engine.
- Waits for engine done with a watchdog, then resets the engine between jobs, because the engine latches done high until reset.
- Sits between the lane controllers and the engine; drives eng_sel to the external buffer muxes.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- MAX_INPUT_DIM, 15, must match engine
- MAX_KERNEL_DIM, 7, must match engine
- TIMEOUT_CYCLES, 16384, max cycles in WAIT before abort
- Derived: IW = $clog2(MAX_INPUT_DIM)+1, KW = $clog2(MAX_KERNEL_DIM)+1, SW = max(1,$clog2(N_REQ))

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  N_REQ  per-requester job request, level
- req_width  in  N_REQ*IW  input width, requester i at [i*IW +: IW]
- req_height  in  N_REQ*IW  input height, same packing
- req_ksize  in  N_REQ*KW  kernel size, packing [i*KW +: KW]
- resp_valid  out  N_REQ  one-cycle completion pulse to granted requester
- resp_err  out  N_REQ  qualifies resp_valid: 1 = rejected or timed out
- busy  out  1  high in any state except IDLE
- eng_start  out  1  engine start
- eng_rst  out  1  engine reset
- eng_done  in  1  engine done, level
- eng_input_width  out  IW  latched config to engine
- eng_input_height  out  IW  latched config to engine
- eng_kernel_size  out  KW  latched config to engine
- eng_sel  out  SW  granted requester index; selects buffer muxes

Behaviour:
- States: IDLE, CHECK, LAUNCH, WAIT, RELEASE, REJECT, ABORT. All outputs are Moore-decoded from state and registers.
- Reset (sync, rst=1 at posedge):
  - state=IDLE, rr_ptr=0, grant=0, config regs=0, timer=0.
  - resp_valid=0, resp_err=0, busy=0, eng_start=0.
  - eng_rst=1 while rst is high. eng_rst = rst | (state==RELEASE) | (state==ABORT).
- IDLE:
  - If any req bit is set, grant the first set bit searching rr_ptr, rr_ptr+1, ... mod N_REQ.
  - Latch grant index into eng_sel, and the granted width/height/ksize into the eng_* regs. Go to CHECK.
  - Otherwise stay in IDLE.
- CHECK (1 cycle): config is invalid if any of the following holds:
  - ksize==0, ksize>MAX_KERNEL_DIM
  - width==0, height==0
  - width>MAX_INPUT_DIM, height>MAX_INPUT_DIM
  - ksize>width, ksize>height
  - Invalid -> REJECT; valid -> LAUNCH.
- LAUNCH (1 cycle): eng_start=1, timer cleared. Next state WAIT.
- WAIT:
  - eng_start=0; timer increments each cycle.
  - eng_done==1 -> RELEASE; this takes priority over timeout when both hold in the same cycle.
  - Otherwise, timer==TIMEOUT_CYCLES-1 -> ABORT.
- RELEASE (1 cycle): eng_rst=1, resp_valid[grant]=1, resp_err=0. rr_ptr=(grant+1) mod N_REQ. Next state IDLE.
- REJECT (1 cycle): resp_valid[grant]=1, resp_err[grant]=1. Engine untouched (no start, no rst). rr_ptr advances. Next state IDLE.
- ABORT (1 cycle): eng_rst=1, resp_valid[grant]=1, resp_err[grant]=1. rr_ptr advances. Next state IDLE.
- Requester rule:
  - Hold req and config stable until resp_valid is seen.
  - Drop req at the same clock edge resp_valid is sampled high, so req is low in the following IDLE cycle.
  - The scheduler ignores config changes after the grant cycle.
- Holding rules:
  - eng_sel and eng_* config stay constant from the cycle after grant through RELEASE/REJECT/ABORT.
  - In IDLE they keep their last values.
- Latency:
  - Grant-to-eng_start = 2 cycles (IDLE edge -> CHECK -> LAUNCH).
  - eng_done high -> resp_valid high on the next cycle.
  - Minimum turnaround between jobs: 5 cycles including IDLE.
- Only one resp_valid bit is ever high at a time.
- A stale eng_done=1 seen in LAUNCH is ignored; it is only sampled in WAIT.
- rst mid-job: immediate return to IDLE, no resp_valid, engine reset via eng_rst.
- req asserted while busy: no effect until IDLE.

Test Plan:
- Single valid job: req[0], w=5, h=5, k=3 with an engine model → eng_start 2 cycles after req; eng_input_width=5, eng_kernel_size=3. Engine done after 9×(9+1)=90 cycles → resp_valid[0]=1, resp_err=0, eng_rst=1 in the same cycle, then busy=0.
- Round-robin: req=4'b1011 held, each requester dropping after its response → service order 0,1,3, then 0 again if it re-requests; rr_ptr=1 after the first job.
- Invalid configs: k=0; k=8; k=6 with w=5; w=16 → each gives resp_valid+resp_err within 2 cycles of grant, eng_start never asserted, eng_rst stays 0.
- Timeout: TIMEOUT_CYCLES=64, engine never raises done → ABORT exactly 64 cycles after entering WAIT; resp_err=1, eng_rst pulse 1 cycle.
- Simultaneous done and timeout in the final WAIT cycle → resp_err=0, normal RELEASE.
- rst asserted 10 cycles into WAIT → busy=0 next cycle, no resp_valid, eng_rst high while rst is high. A subsequent req[2] job completes normally with grant from rr_ptr=0.
